spi_sd_cmd_engine: RTL and testbench
====================================

// Module: spi_sd_cmd_engine
// PURPOSE
//  SPI-mode SD command engine; consumes the com_start/com_cmd/com_arg/speed/close strobes
//  produced by the Avalon register writer. Frames one 6-byte SD command (with CRC7), shifts
//  it out in SPI mode 0, then polls for the R1 response byte. Reports resp/done/timeout.
//  Sits between the register writer and the SD card pins.
// PARAMETERS
//  CLKDIV_BASE   1    SCLK half-period in clk cycles at speed=0; half = CLKDIV_BASE << (2*speed)
//  RESP_TIMEOUT  8    max poll bytes after the frame before timeout (1..255)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  com_start    in   1   one-cycle strobe: start a command
//  com_cmd      in   8   command index; only [5:0] used
//  com_arg      in   24  argument; frame arg = {8'h00, com_arg}
//  speed        in   2   SCLK rate select; sampled on the accepted com_start
//  close        in   1   one-cycle strobe: abort, release card
//  sclk         out  1   SPI clock, idle low (mode 0)
//  mosi         out  1   SPI data out, MSB first
//  miso         in   1   SPI data in
//  cs_n         out  1   chip select, active-low
//  busy         out  1   high from accepted com_start until done/abort
//  done         out  1   one-cycle pulse: transaction finished (response or timeout)
//  timeout      out  1   valid with done: no response within RESP_TIMEOUT bytes
//  resp         out  8   R1 byte; valid with done; holds until next com_start
// BEHAVIOUR
//  Reset: sclk=0, mosi=1, cs_n=1, busy=0, done=0, timeout=0, resp=8'hFF, state=IDLE.
//  Frame: B0={2'b01,cmd[5:0]}, B1=8'h00, B2..B4=com_arg[23:0] MSB first, B5={crc7,1'b1}.
//   CRC7 poly x^7+x^3+1, init 0, over B0..B4 MSB first; computed serially or in parallel.
//   Must be final before B5 shifts.
//  Timing: H = CLKDIV_BASE << (2*speed_latched) clk cycles; each bit = 2H (H low, H high).
//   mosi updates when sclk falls (and on entry to bit 0); miso sampled on sclk rising edge.
//  FSM:
//   IDLE:   com_start -> latch cmd/arg/speed, busy=1, cs_n=0, resp=8'hFF, timeout=0 -> SETUP.
//   SETUP:  hold cs_n low H cycles, sclk low -> SEND.
//   SEND:   shift 48 bits B0..B5 -> POLL; poll_cnt=0.
//   POLL:   shift 8'hFF, capture 8 miso bits; after each byte poll_cnt++.
//           byte[7]==0 -> resp=byte -> FINISH. Else if poll_cnt==RESP_TIMEOUT -> timeout=1,
//           resp=8'hFF -> FINISH. Else next poll byte.
//   FINISH: cs_n=1, mosi=1, sclk=0; next cycle done=1 (one cycle), busy=0 -> IDLE.
//  com_start while busy: ignored, no state change.
//  close (any state): next cycle cs_n=1, sclk=0, mosi=1, busy=0, no done pulse -> IDLE.
//   close + com_start same cycle: close wins, start dropped.
//  speed changes mid-transaction: no effect until next accepted com_start.
//  Reset mid-transaction: all outputs to reset values within one cycle.
//  sclk never glitches: every high phase lasts exactly H cycles; ends low.
//  Counters: bit 0..7, byte 0..5, poll 0..RESP_TIMEOUT, div 0..(64*CLKDIV_BASE-1).
// TESTING
//  1 CMD0: cmd=0x00 arg=0, speed=0, miso model returns FF,01 -> mosi bytes 40 00 00 00 00 95
//    then FF,FF; resp=0x01, timeout=0, done 1 cycle, cs_n high after.
//  2 CMD8: cmd=0x08 arg=0x0001AA -> mosi 48 00 00 01 AA 87; miso 0x05 on 3rd poll -> resp=0x05.
//  3 Timeout: miso tied 1, RESP_TIMEOUT=8 -> 8 poll bytes, done with timeout=1, resp=FF.
//  4 Speed: speed=2, CLKDIV_BASE=1 -> sclk high/low 16 cycles each; total frame 48*32 cycles;
//    speed change to 0 mid-frame has no effect.
//  5 Abort: close during byte 3 of SEND -> cs_n=1, busy=0 next cycle, no done; new com_start works.
//  6 Collisions: com_start while busy ignored; close+com_start same cycle -> stays IDLE;
//    rst mid-POLL -> reset values.

Source files
------------

// File: rtl/spi_sd_cmd_engine.sv
// spi_sd_cmd_engine: SPI-mode (mode 0) SD command engine.
//   Accepts a command strobe, frames a 6-byte SD command with CRC7, shifts it
//   out MSB first, then polls 0xFF bytes until an R1 response (bit7 == 0) or
//   until RESP_TIMEOUT poll bytes have gone by.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   com_start         one-cycle strobe, start a command (ignored while busy)
//   com_cmd[7:0]      command index, [5:0] used
//   com_arg[23:0]     argument, frame arg = {8'h00, com_arg}
//   speed[1:0]        SCLK half-period = CLKDIV_BASE << (2*speed), latched at start
//   close             one-cycle strobe, abort and release the card (wins over start)
//   sclk, mosi, cs_n  SPI pins (sclk idles low, mosi idles high)
//   miso              SPI data in, sampled on sclk rising edge
//   busy              transaction in progress
//   done              one-cycle pulse at end of transaction
//   timeout           valid with done: no R1 within RESP_TIMEOUT bytes
//   resp[7:0]         R1 byte, valid with done, held until next start
module spi_sd_cmd_engine #(
   parameter int unsigned CLKDIV_BASE  = 1,
   parameter int unsigned RESP_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        com_start,
   input  logic [7:0]  com_cmd,
   input  logic [23:0] com_arg,
   input  logic [1:0]  speed,
   input  logic        close,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        cs_n,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [7:0]  resp
);

   localparam int unsigned DIV_W  = $clog2(64 * CLKDIV_BASE);
   localparam int unsigned POLL_W = $clog2(RESP_TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SEND,
      ST_POLL,
      ST_FINISH
   } state_t;

   state_t            state, state_nxt;
   logic              sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, done_nxt, timeout_nxt;
   logic [7:0]        resp_nxt;
   logic [1:0]        speed_q, speed_nxt;
   logic [47:0]       frame_q, frame_nxt;
   logic [7:0]        rx_q, rx_nxt;
   logic [DIV_W-1:0]  div_q, div_nxt, half_m1;
   logic [2:0]        bit_q, bit_nxt;
   logic [2:0]        byte_q, byte_nxt;
   logic [POLL_W-1:0] poll_q, poll_nxt;
   logic [39:0]       hdr;
   logic              div_end;
   logic              unused_cmd_hi;

   // Serial CRC7 (x^7 + x^3 + 1, init 0) over the first five frame bytes.
   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign hdr           = {2'b01, com_cmd[5:0], 8'h00, com_arg};
   assign unused_cmd_hi = ^com_cmd[7:6];

   // Half-period terminal count from the speed latched at start.
   assign half_m1 = DIV_W'((CLKDIV_BASE << {speed_q, 1'b0}) - 1);
   assign div_end = (div_q == half_m1);

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         sclk    <= 1'b0;
         mosi    <= 1'b1;
         cs_n    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         resp    <= 8'hFF;
         speed_q <= 2'd0;
         frame_q <= 48'h0;
         rx_q    <= 8'hFF;
         div_q   <= '0;
         bit_q   <= 3'd0;
         byte_q  <= 3'd0;
         poll_q  <= '0;
      end else begin
         state   <= state_nxt;
         sclk    <= sclk_nxt;
         mosi    <= mosi_nxt;
         cs_n    <= cs_n_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         timeout <= timeout_nxt;
         resp    <= resp_nxt;
         speed_q <= speed_nxt;
         frame_q <= frame_nxt;
         rx_q    <= rx_nxt;
         div_q   <= div_nxt;
         bit_q   <= bit_nxt;
         byte_q  <= byte_nxt;
         poll_q  <= poll_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      sclk_nxt    = sclk;
      mosi_nxt    = mosi;
      cs_n_nxt    = cs_n;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      timeout_nxt = timeout;
      resp_nxt    = resp;
      speed_nxt   = speed_q;
      frame_nxt   = frame_q;
      rx_nxt      = rx_q;
      div_nxt     = div_q;
      bit_nxt     = bit_q;
      byte_nxt    = byte_q;
      poll_nxt    = poll_q;

      if (close) begin
         // Abort from any state: release the card, no done pulse.
         state_nxt = ST_IDLE;
         sclk_nxt  = 1'b0;
         mosi_nxt  = 1'b1;
         cs_n_nxt  = 1'b1;
         busy_nxt  = 1'b0;
         div_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (com_start) begin
                  state_nxt   = ST_SETUP;
                  busy_nxt    = 1'b1;
                  cs_n_nxt    = 1'b0;
                  resp_nxt    = 8'hFF;
                  timeout_nxt = 1'b0;
                  speed_nxt   = speed;
                  frame_nxt   = {hdr, crc7_40(hdr), 1'b1};
                  div_nxt     = '0;
                  bit_nxt     = 3'd0;
                  byte_nxt    = 3'd0;
               end
            end

            // cs_n low for one half-period before the first bit.
            ST_SETUP: begin
               if (div_end) begin
                  state_nxt = ST_SEND;
                  div_nxt   = '0;
                  mosi_nxt  = frame_q[47];
               end else begin
                  div_nxt = div_q + DIV_W'(1);
               end
            end

            // Low half then high half per bit; mosi advances on the falling edge.
            ST_SEND: begin
               if (!div_end) begin
                  div_nxt = div_q + DIV_W'(1);
               end else begin
                  div_nxt = '0;
                  if (!sclk) begin
                     sclk_nxt = 1'b1;
                  end else begin
                     sclk_nxt  = 1'b0;
                     frame_nxt = frame_q << 1;
                     mosi_nxt  = frame_q[46];
                     if (bit_q == 3'd7) begin
                        bit_nxt = 3'd0;
                        if (byte_q == 3'd5) begin
                           state_nxt = ST_POLL;
                           mosi_nxt  = 1'b1;
                           byte_nxt  = 3'd0;
                           poll_nxt  = '0;
                        end else begin
                           byte_nxt = byte_q + 3'd1;
                        end
                     end else begin
                        bit_nxt = bit_q + 3'd1;
                     end
                  end
               end
            end

            // Clock out 0xFF, shift in miso on rising edges, judge each full byte.
            ST_POLL: begin
               if (!div_end) begin
                  div_nxt = div_q + DIV_W'(1);
               end else begin
                  div_nxt = '0;
                  if (!sclk) begin
                     sclk_nxt = 1'b1;
                     rx_nxt   = {rx_q[6:0], miso};
                  end else begin
                     sclk_nxt = 1'b0;
                     if (bit_q == 3'd7) begin
                        bit_nxt  = 3'd0;
                        poll_nxt = poll_q + POLL_W'(1);
                        if (!rx_q[7]) begin
                           resp_nxt  = rx_q;
                           state_nxt = ST_FINISH;
                           cs_n_nxt  = 1'b1;
                        end else if ((poll_q + POLL_W'(1)) == POLL_W'(RESP_TIMEOUT)) begin
                           timeout_nxt = 1'b1;
                           resp_nxt    = 8'hFF;
                           state_nxt   = ST_FINISH;
                           cs_n_nxt    = 1'b1;
                        end
                     end else begin
                        bit_nxt = bit_q + 3'd1;
                     end
                  end
               end
            end

            // Pins already released on entry; pulse done and drop busy.
            ST_FINISH: begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sd_cmd_engine.sv
// Bench for spi_sd_cmd_engine: SD card miso model, mosi byte scoreboard,
// completion scoreboard and sclk phase-length checks.
module tb_spi_sd_cmd_engine;

   localparam int CLKDIV  = 1;
   localparam int RESP_TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        com_start = 1'b0;
   logic [7:0]  com_cmd = 8'h00;
   logic [23:0] com_arg = 24'h0;
   logic [1:0]  speed = 2'd0;
   logic        close = 1'b0;
   logic        miso = 1'b1;
   logic        sclk, mosi, cs_n, busy, done, timeout;
   logic [7:0]  resp;

   int n_total = 0;
   int n_bad   = 0;
   int n_done  = 0;
   int rise_cnt = 0;
   int frame_len = 0;
   int exp_half = 1;
   int mbits = 0;
   int lo_len = 0;
   int hi_len = 0;
   int fcnt = 0;
   logic [7:0] mbyte = 8'h00;
   logic sclk_prev = 1'b0;
   logic done_prev = 1'b0;

   logic [7:0] exp_mosi[$];
   logic [8:0] exp_done[$];
   logic [7:0] poll_bytes[$];

   spi_sd_cmd_engine #(.CLKDIV_BASE(CLKDIV), .RESP_TIMEOUT(RESP_TO)) dut (
      .clk(clk), .rst(rst), .com_start(com_start), .com_cmd(com_cmd),
      .com_arg(com_arg), .speed(speed), .close(close), .sclk(sclk),
      .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy), .done(done),
      .timeout(timeout), .resp(resp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bytewise CRC7 over B0..B4.
   function automatic logic [6:0] tb_crc7(input logic [39:0] d);
      logic [6:0] c;
      logic [7:0] by;
      logic       msb;
      c = 7'h00;
      for (int k = 0; k < 5; k++) begin
         by = d[39 - 8*k -: 8];
         for (int j = 7; j >= 0; j--) begin
            msb = c[6];
            c   = c << 1;
            if (msb ^ by[j]) c = c ^ 7'h09;
         end
      end
      return c;
   endfunction

   function automatic logic [47:0] make_frame(input logic [7:0] c, input logic [23:0] a);
      logic [39:0] h;
      h = {2'b01, c[5:0], 8'h00, a};
      return {h, tb_crc7(h), 1'b1};
   endfunction

   // Card model: miso bit presented before the (idx+1)-th sclk rise.
   function automatic logic model_bit(input int idx);
      int p;
      logic [7:0] b;
      if (idx < 48) return 1'b1;
      p = (idx - 48) / 8;
      if (p >= poll_bytes.size()) return 1'b1;
      b = poll_bytes[p];
      return b[7 - ((idx - 48) % 8)];
   endfunction

   // Pin monitor, sampled on the falling clk edge.
   always @(negedge clk) begin
      logic [8:0] rec;
      if (cs_n) begin
         rise_cnt = 0;
         mbits    = 0;
         lo_len   = 0;
         hi_len   = 0;
         fcnt     = 0;
      end else begin
         if (fcnt == 0) frame_len = 0;
         if (sclk && !sclk_prev) begin
            if (rise_cnt == 0) chk("sclk_first_low", lo_len, 2 * exp_half);
            else               chk("sclk_low", lo_len, exp_half);
            lo_len = 0;
            mbyte  = {mbyte[6:0], mosi};
            mbits++;
            rise_cnt++;
            if (rise_cnt == 48) frame_len = fcnt;
            if (mbits == 8) begin
               mbits = 0;
               chk("mosi_expected", 32'(exp_mosi.size() != 0), 1);
               if (exp_mosi.size() != 0) chk("mosi_byte", 32'(mbyte), 32'(exp_mosi.pop_front()));
            end
         end
         if (sclk) begin
            hi_len++;
         end else begin
            if (hi_len != 0) begin
               chk("sclk_high", hi_len, exp_half);
               hi_len = 0;
            end
            lo_len++;
         end
         fcnt++;
      end
      miso = model_bit(rise_cnt);

      if (done_prev) chk("done_pulse", 32'(done), 0);
      if (done) begin
         n_done++;
         chk("done_expected", 32'(exp_done.size() != 0), 1);
         if (exp_done.size() != 0) begin
            rec = exp_done.pop_front();
            chk("resp", 32'(resp), 32'(rec[7:0]));
            chk("timeout", 32'(timeout), 32'(rec[8]));
         end
         chk("done_csn", 32'(cs_n), 1);
         chk("done_busy", 32'(busy), 0);
      end
      sclk_prev = sclk;
      done_prev = done;
   end

   // Push expectations for one command and pulse com_start.
   task automatic start_cmd(input logic [7:0] c, input logic [23:0] a, input logic [1:0] s,
                            input logic [47:0] frame, input bit aborting);
      int n;
      int nb;
      bit found;
      logic [8:0] rec;
      exp_half = CLKDIV << (2 * int'(s));
      nb = aborting ? 3 : 6;
      for (int k = 0; k < nb; k++) exp_mosi.push_back(frame[47 - 8*k -: 8]);
      if (!aborting) begin
         n     = RESP_TO;
         rec   = {1'b1, 8'hFF};
         found = 1'b0;
         for (int k = 0; k < poll_bytes.size(); k++) begin
            if (!found && k < RESP_TO && !poll_bytes[k][7]) begin
               found = 1'b1;
               n     = k + 1;
               rec   = {1'b0, poll_bytes[k]};
            end
         end
         repeat (n) exp_mosi.push_back(8'hFF);
         exp_done.push_back(rec);
      end
      @(negedge clk);
      com_start = 1'b1;
      com_cmd   = c;
      com_arg   = a;
      speed     = s;
      @(negedge clk);
      com_start = 1'b0;
      com_cmd   = 8'($urandom);
      com_arg   = 24'($urandom);
      speed     = s ^ 2'b10;
      chk("start_busy", 32'(busy), 1);
      chk("start_csn", 32'(cs_n), 0);
      chk("start_resp", 32'(resp), 'hFF);
      chk("start_timeout", 32'(timeout), 0);
   endtask

   task automatic finish_cmd();
      int d0;
      d0 = n_done;
      for (int c = 0; c < 20000 && n_done == d0; c++) @(negedge clk);
      chk("done_seen", 32'(n_done - d0), 1);
      chk("frame_len", frame_len, 96 * exp_half);
      chk("mosi_all_seen", 32'(exp_mosi.size()), 0);
   endtask

   task automatic run_cmd(input logic [7:0] c, input logic [23:0] a, input logic [1:0] s,
                          input logic [47:0] frame);
      start_cmd(c, a, s, frame, 1'b0);
      finish_cmd();
   endtask

   task automatic wait_rise(input int target, input string tag);
      for (int c = 0; c < 5000 && rise_cnt < target; c++) @(negedge clk);
      chk(tag, 32'(rise_cnt >= target), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_mosi", 32'(mosi), 1);
      chk("rst_csn", 32'(cs_n), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_resp", 32'(resp), 'hFF);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // CMD0, R1 on second poll byte
      poll_bytes = '{8'hFF, 8'h01};
      run_cmd(8'h00, 24'h000000, 2'd0, 48'h40_00_00_00_00_95);

      // CMD8, R1 on third poll byte
      poll_bytes = '{8'hFF, 8'hFF, 8'h05};
      run_cmd(8'h08, 24'h0001AA, 2'd0, 48'h48_00_00_01_AA_87);

      // No response: RESP_TIMEOUT poll bytes then timeout
      poll_bytes.delete();
      run_cmd(8'h3A, 24'h000000, 2'd0, 48'h7A_00_00_00_00_FD);

      // speed=2: 16-cycle half periods, speed input flipped after start
      poll_bytes = '{8'hFF, 8'h00};
      run_cmd(8'h37, 24'h000000, 2'd2, 48'h77_00_00_00_00_65);

      // Random commands, arguments and response positions
      for (int t = 0; t < 3; t++) begin
         logic [7:0]  c;
         logic [23:0] a;
         logic [1:0]  s;
         int          npre;
         c    = 8'($urandom);
         a    = 24'($urandom);
         s    = 2'($urandom_range(0, 1));
         npre = $urandom_range(0, 3);
         poll_bytes.delete();
         repeat (npre) poll_bytes.push_back(8'hFF);
         poll_bytes.push_back(8'($urandom_range(0, 127)));
         run_cmd(c, a, s, make_frame(c, a));
      end

      // Abort during byte 3 of the frame
      poll_bytes.delete();
      start_cmd(8'h08, 24'h0001AA, 2'd0, 48'h48_00_00_01_AA_87, 1'b1);
      wait_rise(27, "abort_reach");
      @(negedge clk);
      close = 1'b1;
      @(negedge clk);
      close = 1'b0;
      chk("abort_csn", 32'(cs_n), 1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_sclk", 32'(sclk), 0);
      chk("abort_mosi", 32'(mosi), 1);
      repeat (20) @(negedge clk);
      chk("abort_bytes", 32'(exp_mosi.size()), 0);
      poll_bytes = '{8'h01};
      run_cmd(8'h00, 24'h000000, 2'd0, 48'h40_00_00_00_00_95);

      // com_start while busy is ignored
      poll_bytes = '{8'hFF, 8'hFF, 8'h00};
      start_cmd(8'h37, 24'h000000, 2'd0, 48'h77_00_00_00_00_65, 1'b0);
      wait_rise(10, "busy_reach");
      @(negedge clk);
      com_start = 1'b1;
      com_cmd   = 8'h11;
      com_arg   = 24'h123456;
      speed     = 2'd3;
      @(negedge clk);
      com_start = 1'b0;
      chk("busy_start_busy", 32'(busy), 1);
      chk("busy_start_csn", 32'(cs_n), 0);
      finish_cmd();

      // close + com_start in the same cycle: stays idle
      @(negedge clk);
      close     = 1'b1;
      com_start = 1'b1;
      com_cmd   = 8'h00;
      speed     = 2'd0;
      @(negedge clk);
      close     = 1'b0;
      com_start = 1'b0;
      chk("collide_busy", 32'(busy), 0);
      chk("collide_csn", 32'(cs_n), 1);
      repeat (5) @(negedge clk);
      chk("collide_idle_csn", 32'(cs_n), 1);
      chk("collide_idle_sclk", 32'(sclk), 0);
      chk("collide_resp_hold", 32'(resp), 'h00);

      // Reset in the middle of polling
      poll_bytes.delete();
      start_cmd(8'h3A, 24'h000000, 2'd0, 48'h7A_00_00_00_00_FD, 1'b0);
      wait_rise(52, "poll_reach");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_sclk", 32'(sclk), 0);
      chk("mrst_mosi", 32'(mosi), 1);
      chk("mrst_csn", 32'(cs_n), 1);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_timeout", 32'(timeout), 0);
      chk("mrst_resp", 32'(resp), 'hFF);
      rst = 1'b0;
      exp_mosi.delete();
      exp_done.delete();
      repeat (3) @(negedge clk);

      // Normal operation after reset
      poll_bytes = '{8'hFF, 8'h01};
      run_cmd(8'h3A, 24'h000000, 2'd0, 48'h7A_00_00_00_00_FD);

      repeat (5) @(negedge clk);
      chk("final_queues", 32'(exp_mosi.size() + exp_done.size()), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
